// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by a drop-on-full character FIFO.
// There is no upstream ready: pushes are dropped when the FIFO is full, and each drop is counted.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1),
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_ch,
    output logic          tx,
    output logic          busy,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   overflow_cnt
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_p0, tx_p1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [15:0]   ovf_cnt;

    logic pop, push, drop, full, empty, bit_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign bit_last = (bit_cnt == CW'(CLKS_PER_BIT - 1));
    // A full FIFO still takes a push when the same edge pops its head.
    assign push     = in_valid && (!full || pop);
    assign drop     = in_valid && full && !pop;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_nxt   = mem[rd_ptr];
                    bit_cnt_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (state_nxt)
            START:   tx_p0 = 1'b0;
            DATA:    tx_p0 = shift_nxt[0];
            default: tx_p0 = 1'b1;
        endcase
    end

    // Stage p1: registered line level, tracking the state entered on this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx_p1   <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            tx_p1   <= tx_p0;
        end
    end

    always_ff @(posedge clock) begin
        shift <= shift_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= 16'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= in_ch;
    end

    assign tx           = tx_p1;
    assign busy         = (state != IDLE) || (level != '0);
    assign fifo_level   = level;
    assign overflow_cnt = ovf_cnt;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: framing, back-to-back frames, overflow, reset abort, saturation.
module tb_uart_tx_serializer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_ch;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] overflow_cnt;

    logic        reset_s;
    logic        in_valid_s;
    logic [7:0]  in_ch_s;
    logic        tx_s;
    logic        busy_s;
    logic [1:0]  level_s;
    logic [15:0] ovf_s;

    int total  = 0;
    int passed = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
        .tx(tx), .busy(busy), .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DEPTH(2)) dut_sat (
        .clock(clock), .reset(reset_s), .in_valid(in_valid_s), .in_ch(in_ch_s),
        .tx(tx_s), .busy(busy_s), .fifo_level(level_s), .overflow_cnt(ovf_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Line level expected at cycle i (0..39) of an 8N1 frame at 4 clocks per bit.
    function automatic logic frame_bit(input logic [7:0] ch, input int i);
        int k;
        k = i / 4;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return ch[k-1];
    endfunction

    task automatic check_frame(input logic [7:0] ch, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            check($sformatf("frame_%02h_c%0d", ch, i), {31'd0, tx}, {31'd0, frame_bit(ch, i)});
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        reset_s    = 1'b1;
        in_valid   = 1'b0;
        in_ch      = 8'hC3;
        in_valid_s = 1'b0;
        in_ch_s    = 8'h5A;
        step();
        step();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
        check("rst_sat_ovf", {16'd0, ovf_s}, 32'd0);
        reset      = 1'b0;
        reset_s    = 1'b0;
        in_valid_s = 1'b1;
        step();

        // Single character from idle
        in_valid = 1'b1; in_ch = 8'h41;
        step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("single_level", {29'd0, fifo_level}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        check("single_tx_idle", {31'd0, tx}, 32'd1);
        step();
        check_frame(8'h41, 0, 39);
        check("single_done_busy", {31'd0, busy}, 32'd0);
        check("single_done_level", {29'd0, fifo_level}, 32'd0);
        check("single_done_tx", {31'd0, tx}, 32'd1);

        // Two characters back to back, no idle gap
        in_valid = 1'b1; in_ch = 8'h48;
        step();
        in_ch = 8'h69;
        step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("b2b_level", {29'd0, fifo_level}, 32'd1);
        check_frame(8'h48, 0, 39);
        check_frame(8'h69, 0, 39);
        check("b2b_done_busy", {31'd0, busy}, 32'd0);

        // Six pushes: one popped, four stored, one dropped
        in_valid = 1'b1;
        in_ch = 8'hA5; step();
        in_ch = 8'h3C; step();
        in_ch = 8'h0F; step();
        in_ch = 8'hF0; step();
        in_ch = 8'h81; step();
        in_ch = 8'h77; step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("ovf_cnt", {16'd0, overflow_cnt}, 32'd1);
        check("ovf_level", {29'd0, fifo_level}, 32'd4);
        check_frame(8'hA5, 4, 39);
        check_frame(8'h3C, 0, 39);
        check_frame(8'h0F, 0, 39);
        check_frame(8'hF0, 0, 39);
        check_frame(8'h81, 0, 39);
        check("ovf_done_busy", {31'd0, busy}, 32'd0);
        check("ovf_done_cnt", {16'd0, overflow_cnt}, 32'd1);

        // Full FIFO with push and pop on the same edge
        in_valid = 1'b1;
        in_ch = 8'h11; step();
        in_ch = 8'h22; step();
        in_ch = 8'h33; step();
        in_ch = 8'h44; step();
        in_ch = 8'h55; step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("full_level", {29'd0, fifo_level}, 32'd4);
        check_frame(8'h11, 3, 38);
        check("full_last_stop", {31'd0, tx}, 32'd1);
        in_valid = 1'b1; in_ch = 8'h66;
        step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("pushpop_level", {29'd0, fifo_level}, 32'd4);
        check("pushpop_ovf", {16'd0, overflow_cnt}, 32'd1);
        check_frame(8'h22, 0, 39);
        check_frame(8'h33, 0, 39);
        check_frame(8'h44, 0, 39);
        check_frame(8'h55, 0, 39);
        check_frame(8'h66, 0, 39);
        check("pushpop_done_busy", {31'd0, busy}, 32'd0);

        // Reset during data bit 3 with two characters queued, concurrent push ignored
        in_valid = 1'b1;
        in_ch = 8'hB2; step();
        in_ch = 8'hD4; step();
        in_ch = 8'hE6; step();
        in_valid = 1'b0; in_ch = 8'hC3;
        check("abort_level", {29'd0, fifo_level}, 32'd2);
        check_frame(8'hB2, 1, 17);
        reset = 1'b1; in_valid = 1'b1; in_ch = 8'hEE;
        step();
        reset = 1'b0; in_valid = 1'b0; in_ch = 8'hC3;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_level0", {29'd0, fifo_level}, 32'd0);
        check("abort_ovf", {16'd0, overflow_cnt}, 32'd0);
        step();
        check("abort_idle_tx", {31'd0, tx}, 32'd1);
        in_valid = 1'b1; in_ch = 8'h55;
        step();
        in_valid = 1'b0; in_ch = 8'hC3;
        step();
        check_frame(8'h55, 0, 39);
        check("after_abort_busy", {31'd0, busy}, 32'd0);

        // Overflow counter saturation on the DEPTH=2 instance, fed continuously
        begin
            int n;
            n = 0;
            while (ovf_s !== 16'hFFFF && n < 80000) begin
                step();
                n++;
            end
        end
        check("sat_reached", {16'd0, ovf_s}, 32'h0000FFFF);
        repeat (50) step();
        check("sat_hold", {16'd0, ovf_s}, 32'h0000FFFF);
        check("sat_level", {30'd0, level_s}, 32'd2);
        in_valid_s = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are 2 or greater.
REQ-002 SHALL have parameter DEPTH, default 16: character FIFO entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: character strobe, driven from the SoC top's io_uart_out_valid.
REQ-006 SHALL have port in_ch, input, 8 bits: character, driven from io_uart_out_ch.
REQ-007 SHALL have port tx, output, 1 bit: serial line, 8N1 format, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port fifo_level, output, clog2(DEPTH+1) bits: current FIFO occupancy.
REQ-010 SHALL have port overflow_cnt, output, 16 bits: count of dropped characters; saturates at 16'hFFFF.

Function
REQ-011 SHALL have no ready signal toward upstream; every in_valid=1 cycle is an unconditional push attempt.
REQ-012 SHALL write in_ch into the FIFO on a rising edge where in_valid=1 and the FIFO is not full.
REQ-013 SHALL also accept the push when the FIFO is full and a pop occurs on the same edge; fifo_level then stays DEPTH.
REQ-014 SHALL drop the character and increment overflow_cnt (saturating) when in_valid=1, the FIFO is full and there is no same-edge pop; the FIFO contents stay unchanged.
REQ-015 SHALL update fifo_level as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or on neither.
REQ-016 SHALL implement the FSM states IDLE, START, DATA and STOP, with one bit counter (0..CLKS_PER_BIT-1) and one data-bit index (0..7).
REQ-017 IDLE: tx=1; on an edge where the FIFO is non-empty (registered occupancy, so a same-edge push is not visible), SHALL pop the head into the shift register and go to START.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then SHALL go to DATA with index 0.
REQ-019 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting after each bit; after bit 7 SHALL go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; at the last cycle, if the FIFO is non-empty, SHALL pop and go directly to START (zero idle cycles between frames), else go to IDLE.
REQ-021 tx SHALL be a registered output; each frame spans exactly 10*CLKS_PER_BIT cycles of tx.
REQ-022 Latency: a push on edge E into an empty FIFO with FSM in IDLE SHALL produce a pop on edge E+1, with tx=0 from E+1 onward.
REQ-023 busy SHALL be combinational: (state != IDLE) OR (fifo_level != 0).
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; characters SHALL be transmitted in strict push order.
REQ-025 in_ch SHALL be ignored when in_valid=0.

Reset
REQ-026 While reset=1 on an edge, SHALL set: state IDLE, tx=1, fifo_level=0, FIFO pointers 0, overflow_cnt=0, counters 0.
REQ-027 Reset SHALL take priority over push and pop on the same edge; the character is neither stored nor counted.
REQ-028 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the following edge; queued characters are discarded.

Verification (CLKS_PER_BIT=4, DEPTH=4 unless noted)
REQ-029 Single push of 8'h41 from idle -> tx falls 1 cycle after the push edge; bits 0,1,0,0,0,0,0,1,0 (start first) each 4 cycles, stop=1 for 4 cycles; then busy=0, fifo_level=0.
REQ-030 Push 8'h48 and 8'h69 on consecutive edges -> two frames back-to-back, 80 cycles total, no idle-high gap between the stop bit and the next start bit.
REQ-031 Push 6 characters on consecutive edges from idle -> first popped at the 2nd edge; chars 1-5 fill the FIFO; the 6th is dropped; overflow_cnt=1, fifo_level=4; the 5 stored chars are transmitted in order.
REQ-032 FIFO full, push and pop on the same edge at a frame boundary -> push accepted, overflow_cnt unchanged, fifo_level stays 4.
REQ-033 Reset asserted for 1 cycle during DATA bit 3 of a frame with 2 chars queued -> next edge tx=1, busy=0, fifo_level=0; a later push of 8'h55 transmits correctly.
REQ-034 Force overflow_cnt to 16'hFFFF via 65535 drops (DEPTH=2) -> a further drop leaves it at 16'hFFFF.
